fetch_ctrl: RTL and testbench

Sequencing controller for the IF stage of the 5-stage pipeline. It drives the `PCWrite`/`IF_IDWrite` enables and the IF/ID and ID/EX flushes, and runs a req/ack handshake with a variable-latency instruction memory. It inserts bubbles while a fetch is outstanding, cancels in-flight fetches on a taken branch/jump from E, and merges load-use stalls from the hazard unit. A sticky error flag latches if the memory does not answer within a bounded time.

---
 rtl/fetch_ctrl.sv | 50 +++++
 tb/tb_fetch_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: IF-stage sequencer with imem req/ack handshake, redirect drain, load-use stall merge and sticky fetch timeout
module fetch_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CW = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic PCSrcE,
  input  logic LoadUseStall,
  input  logic imem_ack,
  output logic imem_req,
  output logic PCWrite,
  output logic IF_IDWrite,
  output logic FlushD,
  output logic FlushE,
  output logic fetch_err
);
  typedef enum logic [1:0] {RST_WAIT, FETCH, DRAIN, ERR} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic err_q, err_d, fetch, drain, wait_c, timeout;
  always_comb begin
    fetch = state_q == FETCH;
    drain = state_q == DRAIN;
    wait_c = fetch && !imem_ack && !PCSrcE;
    cnt_inc = cnt_q + 1'b1;
    timeout = wait_c && cnt_inc == CW'(TIMEOUT);
    cnt_d = (wait_c && !timeout) ? cnt_inc : '0;
    err_d = err_q || timeout;
    state_d = (state_q == ERR || timeout) ? ERR :
              (fetch && PCSrcE && !imem_ack) ? DRAIN : FETCH;
    imem_req = fetch;
    PCWrite = fetch && (PCSrcE || (!LoadUseStall && imem_ack));
    IF_IDWrite = fetch ? (PCSrcE || !LoadUseStall) : state_q != RST_WAIT;
    FlushD = fetch ? (PCSrcE || (!LoadUseStall && !imem_ack)) : 1'b1;
    FlushE = fetch ? (PCSrcE || LoadUseStall) : drain ? LoadUseStall : 1'b1;
  end
  assign fetch_err = err_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RST_WAIT;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed self-checking bench for fetch_ctrl with TIMEOUT=4
module tb_fetch_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic PCSrcE = 1'b0;
  logic LoadUseStall = 1'b0;
  logic imem_ack = 1'b1;
  logic imem_req, PCWrite, IF_IDWrite, FlushD, FlushE, fetch_err;
  logic [5:0] obs;
  int checks = 0;
  int errors = 0;
  fetch_ctrl #(.TIMEOUT(4)) dut (
    .clk(clk),
    .reset(reset),
    .PCSrcE(PCSrcE),
    .LoadUseStall(LoadUseStall),
    .imem_ack(imem_ack),
    .imem_req(imem_req),
    .PCWrite(PCWrite),
    .IF_IDWrite(IF_IDWrite),
    .FlushD(FlushD),
    .FlushE(FlushE),
    .fetch_err(fetch_err)
  );
  always #5 clk = ~clk;
  assign obs = {imem_req, PCWrite, IF_IDWrite, FlushD, FlushE, fetch_err};
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== 6'b000110) begin
        errors++;
        $display("FAIL reset[%0d] obs=%b exp=000110", i, obs);
      end
    end
    reset = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== 6'b111000) begin
        errors++;
        $display("FAIL zero_wait[%0d] obs=%b exp=111000", i, obs);
      end
      tick();
    end
  endtask
  task automatic test_three_cycle();
    logic [5:0] exp;
    for (int i = 0; i < 6; i++) begin
      imem_ack = (i % 3) == 2;
      exp = imem_ack ? 6'b111000 : 6'b101100;
      @(negedge clk);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL three_cycle[%0d] obs=%b exp=%b", i, obs, exp);
      end
      tick();
    end
  endtask
  task automatic test_redirect();
    logic [8:0] v [16] = '{
      {3'b000, 6'b101100}, {3'b100, 6'b111110}, {3'b100, 6'b001100}, {3'b001, 6'b111000},
      {3'b000, 6'b101100}, {3'b100, 6'b111110}, {3'b010, 6'b001110}, {3'b001, 6'b111000},
      {3'b000, 6'b101100}, {3'b000, 6'b101100}, {3'b000, 6'b101100}, {3'b101, 6'b111110},
      {3'b000, 6'b101100}, {3'b000, 6'b101100}, {3'b000, 6'b101100}, {3'b001, 6'b111000}
    };
    for (int i = 0; i < 16; i++) begin
      {PCSrcE, LoadUseStall, imem_ack} = v[i][8:6];
      @(negedge clk);
      checks++;
      if (obs !== v[i][5:0]) begin
        errors++;
        $display("FAIL redirect[%0d] obs=%b exp=%b", i, obs, v[i][5:0]);
      end
      tick();
    end
  endtask
  task automatic test_load_use();
    logic [8:0] v [4] = '{
      {3'b011, 6'b100010}, {3'b011, 6'b100010}, {3'b001, 6'b111000}, {3'b001, 6'b111000}
    };
    for (int i = 0; i < 4; i++) begin
      {PCSrcE, LoadUseStall, imem_ack} = v[i][8:6];
      @(negedge clk);
      checks++;
      if (obs !== v[i][5:0]) begin
        errors++;
        $display("FAIL load_use[%0d] obs=%b exp=%b", i, obs, v[i][5:0]);
      end
      tick();
    end
  endtask
  task automatic test_simultaneous();
    logic [8:0] v [3] = '{
      {3'b111, 6'b111110}, {3'b001, 6'b111000}, {3'b111, 6'b111110}
    };
    for (int i = 0; i < 3; i++) begin
      {PCSrcE, LoadUseStall, imem_ack} = v[i][8:6];
      @(negedge clk);
      checks++;
      if (obs !== v[i][5:0]) begin
        errors++;
        $display("FAIL simultaneous[%0d] obs=%b exp=%b", i, obs, v[i][5:0]);
      end
      tick();
    end
  endtask
  task automatic test_ack_wins();
    logic [8:0] v [5] = '{
      {3'b000, 6'b101100}, {3'b000, 6'b101100}, {3'b000, 6'b101100},
      {3'b001, 6'b111000}, {3'b001, 6'b111000}
    };
    for (int i = 0; i < 5; i++) begin
      {PCSrcE, LoadUseStall, imem_ack} = v[i][8:6];
      @(negedge clk);
      checks++;
      if (obs !== v[i][5:0]) begin
        errors++;
        $display("FAIL ack_wins[%0d] obs=%b exp=%b", i, obs, v[i][5:0]);
      end
      tick();
    end
  endtask
  task automatic test_timeout();
    logic [8:0] v [7] = '{
      {3'b000, 6'b101100}, {3'b000, 6'b101100}, {3'b010, 6'b100010}, {3'b000, 6'b101100},
      {3'b000, 6'b001111}, {3'b111, 6'b001111}, {3'b001, 6'b001111}
    };
    for (int i = 0; i < 7; i++) begin
      {PCSrcE, LoadUseStall, imem_ack} = v[i][8:6];
      @(negedge clk);
      checks++;
      if (obs !== v[i][5:0]) begin
        errors++;
        $display("FAIL timeout[%0d] obs=%b exp=%b", i, obs, v[i][5:0]);
      end
      tick();
    end
    {PCSrcE, LoadUseStall, imem_ack} = 3'b001;
    reset = 1'b0;
    #1;
    checks++;
    if (obs !== 6'b000110) begin
      errors++;
      $display("FAIL async_reset obs=%b exp=000110", obs);
    end
    @(negedge clk);
    reset = 1'b1;
    tick();
    @(negedge clk);
    checks++;
    if (obs !== 6'b111000) begin
      errors++;
      $display("FAIL after_reset obs=%b exp=111000", obs);
    end
    tick();
  endtask
  initial begin
    test_reset();
    test_three_cycle();
    test_redirect();
    test_load_use();
    test_simultaneous();
    test_ack_wins();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
